// File: rtl/vending_pkg.sv
// Shared coin encodings, coin values, FSM state type and width defaults
// for the change dispenser.
package vending_pkg;

  localparam int DEF_AMT_W = 8;
  localparam int DEF_CNT_W = 6;

  localparam logic [1:0] COIN_NICKEL  = 2'd0;
  localparam logic [1:0] COIN_DIME    = 2'd1;
  localparam logic [1:0] COIN_QUARTER = 2'd2;

  localparam int unsigned VAL_NICKEL  = 1;
  localparam int unsigned VAL_DIME    = 2;
  localparam int unsigned VAL_QUARTER = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_DONE,
    S_SHORT
  } state_t;

  function automatic int unsigned coin_value(input logic [1:0] sel);
    case (sel)
      COIN_QUARTER: return VAL_QUARTER;
      COIN_DIME:    return VAL_DIME;
      COIN_NICKEL:  return VAL_NICKEL;
      default:      return 0;
    endcase
  endfunction

endpackage

// File: rtl/vending_coin_inventory.sv
// Three saturating per-denomination coin counters: reset load, refill add,
// and one-coin dispense decrement, all of which may coincide in one cycle.
module vending_coin_inventory
  import vending_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int INIT_Q = 20,
  parameter int INIT_D = 20,
  parameter int INIT_N = 20
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             refill_valid,
  input  logic [1:0]       refill_sel,
  input  logic [CNT_W-1:0] refill_cnt,
  input  logic             take_valid,
  input  logic [1:0]       take_sel,
  output logic [CNT_W-1:0] inv_q,
  output logic [CNT_W-1:0] inv_d,
  output logic [CNT_W-1:0] inv_n
);

  // One extra bit holds inv + refill; a take only ever follows a nonzero count.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cur,
                                            input logic add,
                                            input logic [CNT_W-1:0] cnt,
                                            input logic sub);
    logic [CNT_W:0] sum;
    sum = {1'b0, cur} + (add ? {1'b0, cnt} : '0) - (CNT_W+1)'(sub);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      inv_q <= CNT_W'(INIT_Q);
      inv_d <= CNT_W'(INIT_D);
      inv_n <= CNT_W'(INIT_N);
    end else begin
      inv_q <= bump(inv_q, refill_valid && (refill_sel == COIN_QUARTER), refill_cnt,
                    take_valid && (take_sel == COIN_QUARTER));
      inv_d <= bump(inv_d, refill_valid && (refill_sel == COIN_DIME), refill_cnt,
                    take_valid && (take_sel == COIN_DIME));
      inv_n <= bump(inv_n, refill_valid && (refill_sel == COIN_NICKEL), refill_cnt,
                    take_valid && (take_sel == COIN_NICKEL));
    end
  end

endmodule

// File: rtl/vending_change_dispenser.sv
// Change payout controller: accepts an amount, then drives the hopper one
// coin at a time, largest coin first, ending with a done or short pulse.
module vending_change_dispenser
  import vending_pkg::*;
#(
  parameter int AMT_W  = DEF_AMT_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int INIT_Q = 20,
  parameter int INIT_D = 20,
  parameter int INIT_N = 20
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amt,
  output logic             req_ready,
  output logic             coin_valid,
  output logic [1:0]       coin_sel,
  input  logic             coin_ack,
  input  logic             refill_valid,
  input  logic [1:0]       refill_sel,
  input  logic [CNT_W-1:0] refill_cnt,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] short_amt,
  output logic [CNT_W-1:0] inv_q,
  output logic [CNT_W-1:0] inv_d,
  output logic [CNT_W-1:0] inv_n
);

  state_t           state;
  logic [AMT_W-1:0] remaining;
  logic             take;

  assign take = (state == S_ISSUE) && coin_valid && coin_ack;

  vending_coin_inventory #(
    .CNT_W  (CNT_W),
    .INIT_Q (INIT_Q),
    .INIT_D (INIT_D),
    .INIT_N (INIT_N)
  ) u_inv (
    .clock        (clock),
    .rst          (rst),
    .refill_valid (refill_valid),
    .refill_sel   (refill_sel),
    .refill_cnt   (refill_cnt),
    .take_valid   (take),
    .take_sel     (coin_sel),
    .inv_q        (inv_q),
    .inv_d        (inv_d),
    .inv_n        (inv_n)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      coin_valid <= 1'b0;
      coin_sel   <= COIN_NICKEL;
      done       <= 1'b0;
      short      <= 1'b0;
      short_amt  <= '0;
      remaining  <= '0;
    end else begin
      done  <= 1'b0;
      short <= 1'b0;
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_ready && req_valid) begin
            req_ready <= 1'b0;
            remaining <= req_amt;
            short_amt <= '0;
            state     <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (remaining == '0) begin
            state <= S_DONE;
          end else if (remaining >= AMT_W'(VAL_QUARTER) && inv_q != '0) begin
            coin_sel <= COIN_QUARTER;
            state    <= S_ISSUE;
          end else if (remaining >= AMT_W'(VAL_DIME) && inv_d != '0) begin
            coin_sel <= COIN_DIME;
            state    <= S_ISSUE;
          end else if (remaining >= AMT_W'(VAL_NICKEL) && inv_n != '0) begin
            coin_sel <= COIN_NICKEL;
            state    <= S_ISSUE;
          end else begin
            state <= S_SHORT;
          end
        end
        // coin_valid rises one cycle after entering, which sets the k+2 latency.
        S_ISSUE: begin
          if (!coin_valid) begin
            coin_valid <= 1'b1;
          end else if (coin_ack) begin
            coin_valid <= 1'b0;
            remaining  <= remaining - AMT_W'(coin_value(coin_sel));
            state      <= S_SELECT;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        S_SHORT: begin
          short     <= 1'b1;
          short_amt <= remaining;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_change_dispenser.sv
// Self-checking bench for vending_change_dispenser: vector table, directed
// corner sequences and a randomized run against a greedy payout model.
module tb_vending_change_dispenser;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_amt = '0;
  logic       req_ready;
  logic       coin_valid;
  logic [1:0] coin_sel;
  logic       coin_ack = 1'b0;
  logic       refill_valid = 1'b0;
  logic [1:0] refill_sel = '0;
  logic [5:0] refill_cnt = '0;
  logic       done;
  logic       short;
  logic [7:0] short_amt;
  logic [5:0] inv_q, inv_d, inv_n;

  vending_change_dispenser #(
    .AMT_W (8), .CNT_W (6), .INIT_Q (20), .INIT_D (20), .INIT_N (20)
  ) dut (
    .clock (clock), .rst (rst),
    .req_valid (req_valid), .req_amt (req_amt), .req_ready (req_ready),
    .coin_valid (coin_valid), .coin_sel (coin_sel), .coin_ack (coin_ack),
    .refill_valid (refill_valid), .refill_sel (refill_sel), .refill_cnt (refill_cnt),
    .done (done), .short (short), .short_amt (short_amt),
    .inv_q (inv_q), .inv_d (inv_d), .inv_n (inv_n)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  int   seq[$];
  bit   got_done, got_short;
  int   got_samt;
  int   lat_first, lat_end;

  // model: index 0 nickel, 1 dime, 2 quarter
  int   m_inv[3];
  int   m_seq[$];
  int   m_rem;

  typedef struct {
    logic [7:0] amt;
    int nq, nd, nn;
    int iq, id, inn;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int count_sel(input int sel);
    int c = 0;
    foreach (seq[i]) if (seq[i] == sel) c++;
    return c;
  endfunction

  function automatic void model_pay(input int amt);
    int val[3] = '{1, 2, 5};
    int pick;
    m_seq.delete();
    m_rem = amt;
    while (m_rem > 0) begin
      pick = -1;
      for (int d = 2; d >= 0; d--)
        if (pick < 0 && m_rem >= val[d] && m_inv[d] > 0) pick = d;
      if (pick < 0) break;
      m_seq.push_back(pick);
      m_rem -= val[pick];
      m_inv[pick]--;
    end
  endfunction

  task automatic accept(input logic [7:0] amt);
    int n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    if (!req_ready) check("req_ready wait", 0, 1);
    req_valid = 1'b1;
    req_amt = amt;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic serve(input int ack_dly);
    int cyc = 0;
    bit fin = 0;
    seq.delete();
    got_done = 0; got_short = 0; got_samt = -1; lat_first = -1; lat_end = -1;
    while (!fin && cyc < 500) begin
      if (done) begin
        got_done = 1; fin = 1; lat_end = cyc;
      end else if (short) begin
        got_short = 1; got_samt = int'(short_amt); fin = 1; lat_end = cyc;
      end else if (coin_valid) begin
        if (lat_first < 0) lat_first = cyc;
        seq.push_back(int'(coin_sel));
        repeat (ack_dly) begin tick(); cyc++; end
        coin_ack = 1'b1;
        tick(); cyc++;
        coin_ack = 1'b0;
      end else begin
        tick(); cyc++;
      end
    end
    if (!fin) check("payout timeout", 0, 1);
  endtask

  task automatic pay(input logic [7:0] amt, input int ack_dly);
    accept(amt);
    serve(ack_dly);
  endtask

  task automatic wait_coin();
    int n = 0;
    while (!coin_valid && n < 20) begin tick(); n++; end
    if (!coin_valid) check("coin_valid wait", 0, 1);
  endtask

  task automatic refill(input logic [1:0] sel, input logic [5:0] cnt);
    refill_valid = 1'b1; refill_sel = sel; refill_cnt = cnt;
    tick();
    refill_valid = 1'b0; refill_sel = '0; refill_cnt = '0;
  endtask

  task automatic check_inv(input string tag, input int q, input int d, input int n);
    check({tag, " inv_q"}, int'(inv_q), q);
    check({tag, " inv_d"}, int'(inv_d), d);
    check({tag, " inv_n"}, int'(inv_n), n);
  endtask

  initial begin
    bit seen;
    int sel, cnt, amt;

    tbl[0] = '{8'd0,  0, 0, 0, 19, 19, 19};
    tbl[1] = '{8'd13, 2, 1, 1, 17, 18, 18};
    tbl[2] = '{8'd4,  0, 2, 0, 17, 16, 18};
    tbl[3] = '{8'd1,  0, 0, 1, 17, 16, 17};
    tbl[4] = '{8'd5,  1, 0, 0, 16, 16, 17};
    tbl[5] = '{8'd3,  0, 1, 1, 16, 15, 16};

    repeat (2) tick();
    check("reset req_ready", int'(req_ready), 1);
    check("reset coin_valid", int'(coin_valid), 0);
    rst = 1'b0;
    tick();
    check("reset coin_sel", int'(coin_sel), 0);
    check("reset done", int'(done), 0);
    check("reset short", int'(short), 0);
    check("reset short_amt", int'(short_amt), 0);
    check_inv("reset", 20, 20, 20);

    // amount 8: quarter, dime, nickel
    pay(8'd8, 1);
    check("amt8 coins", seq.size(), 3);
    if (seq.size() == 3) begin
      check("amt8 coin0", seq[0], 2);
      check("amt8 coin1", seq[1], 1);
      check("amt8 coin2", seq[2], 0);
    end
    check("amt8 first coin latency", lat_first, 2);
    check("amt8 done", int'(got_done), 1);
    check_inv("amt8", 19, 19, 19);

    // zero amount: done two cycles after accept, ready the cycle after
    pay(8'd0, 0);
    check("zero coins", seq.size(), 0);
    check("zero done latency", lat_end, 2);
    check("zero done", int'(got_done), 1);
    check("zero ready during done", int'(req_ready), 0);
    tick();
    check("zero ready after done", int'(req_ready), 1);
    check("zero done pulse width", int'(done), 0);

    foreach (tbl[i]) begin
      pay(tbl[i].amt, i % 3);
      check($sformatf("tbl%0d quarters", i), count_sel(2), tbl[i].nq);
      check($sformatf("tbl%0d dimes", i), count_sel(1), tbl[i].nd);
      check($sformatf("tbl%0d nickels", i), count_sel(0), tbl[i].nn);
      check($sformatf("tbl%0d done", i), int'(got_done), 1);
      check_inv($sformatf("tbl%0d", i), tbl[i].iq, tbl[i].id, tbl[i].inn);
    end

    // stray ack in idle
    tick();
    coin_ack = 1'b1; tick(); coin_ack = 1'b0; tick();
    check("stray ack coin_valid", int'(coin_valid), 0);
    check("stray ack req_ready", int'(req_ready), 1);
    check_inv("stray ack", 16, 15, 16);

    // request during ISSUE must be ignored
    accept(8'd2);
    wait_coin();
    check("busy req coin_sel", int'(coin_sel), 1);
    req_valid = 1'b1; req_amt = 8'd50;
    tick(); tick();
    check("busy req coin_valid held", int'(coin_valid), 1);
    check("busy req coin_sel held", int'(coin_sel), 1);
    req_valid = 1'b0;
    coin_ack = 1'b1; tick(); coin_ack = 1'b0;
    serve(0);
    check("busy req extra coins", seq.size(), 0);
    check("busy req done", int'(got_done), 1);
    seen = 0;
    repeat (6) begin tick(); if (coin_valid) seen = 1; end
    check("busy req not latched", int'(seen), 0);
    check("busy req ready", int'(req_ready), 1);
    check_inv("busy req", 16, 14, 16);

    // refill and ack on the same denomination in one cycle
    accept(8'd1);
    wait_coin();
    check("refill+ack coin_sel", int'(coin_sel), 0);
    coin_ack = 1'b1; refill_valid = 1'b1; refill_sel = 2'd0; refill_cnt = 6'd5;
    tick();
    coin_ack = 1'b0; refill_valid = 1'b0; refill_cnt = '0;
    serve(0);
    check("refill+ack done", int'(got_done), 1);
    check_inv("refill+ack", 16, 14, 20);

    // saturation and ignored selector
    refill(2'd2, 6'd44);
    check("refill q to 60", int'(inv_q), 60);
    refill(2'd2, 6'd10);
    check("refill q saturates", int'(inv_q), 63);
    refill(2'd3, 6'd7);
    check_inv("refill sel3", 63, 14, 20);

    // drain nickels, then 6 pays one quarter and comes up 1 short
    repeat (20) pay(8'd1, 0);
    check_inv("drained", 63, 14, 0);
    pay(8'd6, 1);
    check("short coins", seq.size(), 1);
    if (seq.size() == 1) check("short coin0", seq[0], 2);
    check("short pulse", int'(got_short), 1);
    check("short amount", got_samt, 1);
    check("short no done", int'(got_done), 0);
    tick();
    check("short pulse width", int'(short), 0);
    check("short_amt held", int'(short_amt), 1);
    accept(8'd2);
    check("short_amt cleared", int'(short_amt), 0);
    serve(0);
    check("after short done", int'(got_done), 1);
    check_inv("after short", 62, 13, 0);

    // async reset while a coin is in flight
    accept(8'd5);
    wait_coin();
    rst = 1'b1;
    #1;
    check("midreset coin_valid", int'(coin_valid), 0);
    check("midreset req_ready", int'(req_ready), 1);
    check("midreset coin_sel", int'(coin_sel), 0);
    check_inv("midreset", 20, 20, 20);
    tick();
    rst = 1'b0;
    tick();

    // randomized payouts against the greedy model
    m_inv = '{20, 20, 20};
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        sel = int'($urandom_range(0, 3));
        cnt = int'($urandom_range(0, 63));
        refill(2'(sel), 6'(cnt));
        if (sel != 3) m_inv[sel] = (m_inv[sel] + cnt > 63) ? 63 : m_inv[sel] + cnt;
      end
      amt = int'($urandom_range(0, 30));
      model_pay(amt);
      pay(8'(amt), int'($urandom_range(0, 3)));
      seen = (seq.size() == m_seq.size());
      if (seen) foreach (seq[i]) if (seq[i] != m_seq[i]) seen = 0;
      check($sformatf("rand%0d amt %0d coin sequence", it, amt), int'(seen), 1);
      check($sformatf("rand%0d done", it), int'(got_done), int'(m_rem == 0));
      check($sformatf("rand%0d short", it), int'(got_short), int'(m_rem != 0));
      if (m_rem != 0) check($sformatf("rand%0d short_amt", it), got_samt, m_rem);
      check_inv($sformatf("rand%0d", it), m_inv[2], m_inv[1], m_inv[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vending_change_dispenser.md
Name: vending_change_dispenser

Overview:
Pays coins back to the customer. It is the payout counterpart of the coin-accepting vending controller. It takes a change amount over a valid/ready request, then drives a coin hopper one coin at a time, largest coin first. The controller issues refunds and over-payment change to this block; the physical hopper acknowledges each coin it releases.

Parameters:
AMT_W, 8, width of amount fields; amounts are in units of 5 cents (1 = nickel, 2 = dime, 5 = quarter)
CNT_W, 6, width of each per-denomination inventory counter; counters saturate at 2^CNT_W-1
INIT_Q, 20, quarter inventory loaded at reset
INIT_D, 20, dime inventory loaded at reset
INIT_N, 20, nickel inventory loaded at reset

Ports:
clock  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  change request present
req_amt  in  AMT_W  requested change, 5-cent units
req_ready  out  1  block can accept a request
coin_valid  out  1  hopper must release one coin of coin_sel
coin_sel  out  2  0=nickel, 1=dime, 2=quarter, 3 unused
coin_ack  in  1  hopper released the coin (1-cycle pulse)
refill_valid  in  1  add coins to inventory
refill_sel  in  2  denomination to refill (same encoding as coin_sel)
refill_cnt  in  CNT_W  number of coins added
done  out  1  1-cycle pulse: full amount paid
short  out  1  1-cycle pulse: payout stopped, inventory insufficient
short_amt  out  AMT_W  unpaid remainder; valid with short, held until next accept
inv_q, inv_d, inv_n  out  CNT_W each  current inventory

Behaviour:
- Reset (async, immediate):
  - state=IDLE, req_ready=1, coin_valid=0, coin_sel=0.
  - done=0, short=0, short_amt=0, remaining=0.
  - inv_q/d/n = INIT_Q/D/N.
  - Applies mid-payout too: the coin in flight is abandoned and no ack is expected.
- States IDLE, SELECT, ISSUE, DONE, SHORT; encodings are defined in the package.
- IDLE:
  - req_ready=1.
  - On req_valid, latch remaining=req_amt, clear short_amt, go to SELECT.
- SELECT (one cycle, req_ready=0):
  - If remaining==0, go to DONE.
  - Otherwise greedy choice: quarter if remaining>=5 and inv_q>0; else dime if remaining>=2 and inv_d>0; else nickel if remaining>=1 and inv_n>0.
  - Register coin_sel and go to ISSUE.
  - If no coin qualifies, go to SHORT.
  - The greedy choice is normative and is not backtracked (e.g. remaining=6, inv_n=0 ends SHORT with 1 unpaid).
- ISSUE:
  - coin_valid=1; coin_sel is stable until ack.
  - On coin_ack: subtract the coin value from remaining, decrement that inventory, go to SELECT; coin_valid drops the next cycle.
  - No timeout; waits indefinitely.
- DONE: done=1 for one cycle, then IDLE.
- SHORT: short=1 for one cycle, short_amt=remaining, then IDLE.
- Latency: request accepted at edge k → coin_valid high after edge k+2. A zero-amount request gives done after edge k+2 with no coins.
- coin_ack while coin_valid=0 is ignored.
- refill_valid is accepted in any state:
  - inventory += refill_cnt, saturating at max.
  - refill_sel=3 is ignored.
  - If refill and coin_ack hit the same denomination in the same cycle, result = sat(inv + refill_cnt − 1).
  - A refill during SELECT becomes visible on the next SELECT.
- req_valid outside IDLE is ignored, with no queuing. The requester holds req_valid until req_ready.
- Arithmetic is unsigned. remaining never underflows, because a coin is selected only if its value ≤ remaining.

Decomposition:
- Package vending_pkg holds:
  - coin encodings COIN_NICKEL/DIME/QUARTER;
  - coin values in units (1/2/5);
  - state enum typedef;
  - AMT_W/CNT_W defaults.
- One sub-module, vending_coin_inventory, holds the three saturating counters: reset load, refill add, dispense decrement and simultaneous-event rule.
- The FSM stays in vending_change_dispenser.

Test Plan:
- Reset, then req_amt=8 with the hopper acking 1 cycle after each coin_valid → coin_sel sequence quarter, dime, nickel; done pulse; inv_q/d/n = 19/19/19.
- req_amt=0 → no coin_valid, done 2 cycles after accept, req_ready returns 1 the cycle after done.
- INIT_N=0, req_amt=6 → one quarter dispensed, then short=1, short_amt=1; inv_q=19.
- Assert rst during ISSUE with coin_valid=1 → coin_valid, req_ready=1 immediately (before the clock edge); inventories back to INIT.
- refill_valid with refill_sel=0, refill_cnt=5 in the same cycle as coin_ack for a nickel, inv_n=20 → inv_n=24. Refill inv_q=60 by 10 with CNT_W=6 → 63.
- Stray coin_ack in IDLE, and req_valid during ISSUE → no state change, no inventory change, second request not latched.
